// File: rtl/dual_bin2bcd_seq.sv
// dual_bin2bcd_seq: two-channel sequential binary-to-BCD converter (shift-add-3).
// Accepts two unsigned WIDTH-bit values per valid/ready transaction and, WIDTH
// cycles later, presents both as packed BCD (digit 0 in bits [3:0]). The result
// is held until the downstream side accepts it.
//
// Ports:
//   CLK50MHZ   in   clock, rising edge
//   RESET      in   synchronous, active-high reset
//   in_valid   in   upstream presents in_a/in_b
//   in_ready   out  idle, can accept a transaction
//   in_a/in_b  in   binary values, WIDTH bits each
//   out_valid  out  bcd_a/bcd_b hold a completed result
//   out_ready  in   downstream accepts the result
//   bcd_a/b    out  packed BCD, 4*DIGITS bits each
//   busy       out  conversion in progress
//
// DIGITS must satisfy 10**DIGITS > 2**WIDTH - 1.

`timescale 1ns / 1ps

module dual_bin2bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  CLK50MHZ,
  input  logic                  RESET,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_a,
  output logic [4*DIGITS-1:0]   bcd_b,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam int unsigned BcdW = 4 * DIGITS;
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic [WIDTH-1:0] r_bin_a, r_bin_b;
  logic [BcdW-1:0]  r_acc_a, r_acc_b;
  logic [CntW-1:0]  r_cnt;
  logic [BcdW-1:0]  r_bcd_a, r_bcd_b;

  logic [BcdW-1:0]  w_adj_a, w_adj_b;
  logic [BcdW-1:0]  w_acc_a_nxt, w_acc_b_nxt;
  logic [WIDTH-1:0] w_bin_a_nxt, w_bin_b_nxt;
  logic             w_last;

  // Add 3 to every nibble >= 5; nibbles are independent, no carry between them.
  function automatic logic [BcdW-1:0] add3(input logic [BcdW-1:0] acc);
    logic [BcdW-1:0] res;
    res = acc;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        res[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

  // One double-dabble iteration per channel: adjust, then shift {bcd, bin}
  // left with the binary MSB entering BCD bit 0.
  always_comb begin
    w_adj_a     = add3(r_acc_a);
    w_adj_b     = add3(r_acc_b);
    w_acc_a_nxt = {w_adj_a[BcdW-2:0], r_bin_a[WIDTH-1]};
    w_acc_b_nxt = {w_adj_b[BcdW-2:0], r_bin_b[WIDTH-1]};
    w_bin_a_nxt = r_bin_a << 1;
    w_bin_b_nxt = r_bin_b << 1;
    w_last      = (r_cnt == LastIter);
  end

  // State register
  always_ff @(posedge CLK50MHZ) begin
    if (RESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (in_valid)  w_state_nxt = StShift;
      StShift: if (w_last)    w_state_nxt = StDone;
      StDone:  if (out_ready) w_state_nxt = StIdle;
      default:                w_state_nxt = StIdle;
    endcase
  end

  // Datapath; result registers load only on the final iteration so
  // intermediate accumulators never reach the outputs.
  always_ff @(posedge CLK50MHZ) begin
    if (RESET) begin
      r_bin_a <= '0;
      r_bin_b <= '0;
      r_acc_a <= '0;
      r_acc_b <= '0;
      r_cnt   <= '0;
      r_bcd_a <= '0;
      r_bcd_b <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_bin_a <= in_a;
            r_bin_b <= in_b;
            r_acc_a <= '0;
            r_acc_b <= '0;
            r_cnt   <= '0;
          end
        end
        StShift: begin
          r_acc_a <= w_acc_a_nxt;
          r_acc_b <= w_acc_b_nxt;
          r_bin_a <= w_bin_a_nxt;
          r_bin_b <= w_bin_b_nxt;
          r_cnt   <= r_cnt + CntW'(1);
          if (w_last) begin
            r_bcd_a <= w_acc_a_nxt;
            r_bcd_b <= w_acc_b_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake flags decode registered state only.
  assign in_ready  = (r_state == StIdle);
  assign busy      = (r_state == StShift);
  assign out_valid = (r_state == StDone);
  assign bcd_a     = r_bcd_a;
  assign bcd_b     = r_bcd_b;

endmodule

// File: doc/dual_bin2bcd_seq.md
# dual_bin2bcd_seq

Sequential two-channel binary-to-BCD converter (shift-add-3, "double dabble") that feeds the 7-segment scan driver. It replaces that driver's combinational divide-by-10 digit split. It accepts two unsigned binary values per transaction over a valid/ready handshake and produces each value as packed BCD digits after a fixed WIDTH-cycle conversion. It holds the result until the downstream driver accepts it.

## Interface
Parameters:
- WIDTH, 8, bit width of each binary input.
- DIGITS, 3, BCD digits per channel; must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
- CLK50MHZ  input  1  sole clock, all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents in_a/in_b.
- in_ready  output  1  block can accept a transaction.
- in_a  input  WIDTH  channel A binary value (display's first pair).
- in_b  input  WIDTH  channel B binary value (display's second pair).
- out_valid  output  1  bcd_a/bcd_b hold a completed result.
- out_ready  input  1  downstream accepts the result.
- bcd_a  output  4*DIGITS  channel A BCD, digit 0 (ones) in bits [3:0].
- bcd_b  output  4*DIGITS  channel B BCD, same packing.
- busy  output  1  high while in SHIFT state.

## Operation
- Clocking and reset: one clock (CLK50MHZ). Reset is synchronous, active-high (RESET), sampled on the rising edge.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture in_a and in_b into shift registers, clear both BCD accumulators, clear the iteration counter, and go to SHIFT.
- SHIFT: each edge performs one iteration on both channels in parallel.
  - For every BCD nibble ≥5, add 3.
  - Then shift {bcd, bin} left by one, with the binary MSB entering BCD bit 0.
  - The counter increments. After the iteration with counter = WIDTH-1, go to DONE.
- DONE:
  - out_valid=1. bcd_a and bcd_b hold the final accumulators.
  - On an edge with out_ready=1, go to IDLE.
  - While out_ready=0, the outputs and state are frozen. in_valid is ignored.
- Outputs bcd_a/bcd_b are registered and change only when entering DONE or on reset. During SHIFT they keep their previous value; do not expose intermediate accumulators.
- Width rules:
  - The add-3 adjust is computed on 4-bit nibbles with no carry between nibbles. A nibble never exceeds 9 after the final shift.
  - Counter width is ceil(log2(WIDTH))+1.
- in_ready, out_valid and busy are decoded from registered state only, with no combinational path from inputs.
- Reset in any state, including mid-SHIFT or mid-DONE stall:
  - Next state IDLE.
  - bcd_a=bcd_b=0, out_valid=0, busy=0, in_ready=1.
  - The in-flight conversion is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, bcd_a=0, bcd_b=0.
- Acceptance edge N: in_valid=1 and in_ready=1. After edge N: in_ready=0, busy=1.
- Iterations happen on edges N+1 … N+WIDTH.
- After edge N+WIDTH: busy=0, out_valid=1, results valid. Latency is WIDTH edges from acceptance (8 by default).
- Hand-off edge M: out_valid=1 and out_ready=1. After M: out_valid=0, in_ready=1. bcd outputs retain the last result.
- Earliest next acceptance is edge M+1. Maximum throughput with out_ready tied high is one result per WIDTH+2 cycles (10).
- in_valid during SHIFT or DONE has no effect. Upstream must hold in_a/in_b only through the acceptance edge.
- Simultaneous RESET with in_valid or out_ready: RESET wins.

## Test plan
- Reset: assert RESET 2 cycles, release -> in_ready=1, out_valid=0, busy=0, bcd_a=bcd_b=12'h000.
- Single conversion: in_a=255, in_b=0, in_valid pulsed one cycle, out_ready=1 -> out_valid rises exactly 8 edges after acceptance with bcd_a=12'h255, bcd_b=12'h000. busy is high for exactly 8 cycles. in_ready returns 1 after the hand-off edge.
- Backpressure: in_a=99, in_b=42, out_ready=0 for 5 cycles after done, in_valid=1 with in_a=7 throughout -> bcd_a=12'h099 and bcd_b=12'h042 stable while stalled, in_ready=0. The value 7 is not accepted until after hand-off.
- Back-to-back: in_valid and out_ready tied 1, inputs sequence (10,200),(9,100),(128,1) -> results 12'h010/12'h200, 12'h009/12'h100, 12'h128/12'h001, with out_valid pulses spaced exactly 10 cycles.
- Mid-conversion reset: accept (123,45), assert RESET on the 4th SHIFT edge -> next cycle in_ready=1, out_valid=0, bcd=0. A following (123,45) conversion yields 12'h123/12'h045.
- Exhaustive: all 256×256 pairs with random out_ready stalls -> each bcd digit matches value/100, (value/10)%10, value%10 against the scoreboard, and every nibble is ≤9.
